// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 response encodings and burst-length width
package axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int LEN_WIDTH = 8;
endpackage

// File: rtl/axi_err_slv.sv
// axi_err_slv: terminating AXI4 responder that answers every burst with an error response
module axi_err_slv
  import axi_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int DATA_WIDTH = 64,
  parameter logic [1:0] RESP = RESP_DECERR,
  parameter logic [63:0] RDATA = 64'hBADC_AB1E_DEAD_BEEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic aw_valid_i,
  output logic aw_ready_o,
  input  logic [ID_WIDTH-1:0] aw_id_i,
  input  logic w_valid_i,
  input  logic w_last_i,
  output logic w_ready_o,
  output logic b_valid_o,
  input  logic b_ready_i,
  output logic [ID_WIDTH-1:0] b_id_o,
  output logic [1:0] b_resp_o,
  input  logic ar_valid_i,
  output logic ar_ready_o,
  input  logic [ID_WIDTH-1:0] ar_id_i,
  input  logic [LEN_WIDTH-1:0] ar_len_i,
  output logic r_valid_o,
  input  logic r_ready_i,
  output logic [ID_WIDTH-1:0] r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0] r_resp_o,
  output logic r_last_o
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  w_state_e w_state, w_next;
  r_state_e r_state, r_next;
  logic [LEN_WIDTH-1:0] cnt;
  logic aw_hs, ar_hs, r_hs;
  assign aw_ready_o = w_state == W_IDLE;
  assign w_ready_o = w_state == W_DATA;
  assign b_valid_o = w_state == W_RESP;
  assign b_resp_o = RESP;
  assign ar_ready_o = r_state == R_IDLE;
  assign r_valid_o = r_state == R_DATA;
  assign r_last_o = r_valid_o && cnt == '0;
  assign r_resp_o = RESP;
  assign r_data_o = DATA_WIDTH'(RDATA);
  assign aw_hs = aw_ready_o && aw_valid_i;
  assign ar_hs = ar_ready_o && ar_valid_i;
  assign r_hs = r_valid_o && r_ready_i;
  // write path: wait for AW, sink W until WLAST, then hold B until accepted
  always_comb begin
    w_next = w_state;
    if (aw_hs) w_next = W_DATA;
    else if (w_ready_o && w_valid_i && w_last_i) w_next = W_RESP;
    else if (b_valid_o && b_ready_i) w_next = W_IDLE;
  end
  // write state and latched AW ID
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      b_id_o <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) b_id_o <= aw_id_i;
    end
  end
  // read path: stream ARLEN+1 beats, return to idle after the last one
  always_comb begin
    r_next = r_state;
    if (ar_hs) r_next = R_DATA;
    else if (r_hs && r_last_o) r_next = R_IDLE;
  end
  // read state, latched AR ID and remaining-beat counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      r_id_o <= '0;
      cnt <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_id_o <= ar_id_i;
        cnt <= ar_len_i;
      end else if (r_hs && !r_last_o) cnt <= cnt - 1'b1;
    end
  end
endmodule
